vproc_div_res_pack: RTL and testbench
=====================================

Name: vproc_div_res_pack

Overview:
- Downstream neighbour of the vector DIV unit.
- Accepts DIV_OP_W-wide result chunks with byte masks from the DIV result buffer. Assembles them into full VREG_W-wide vector-register writes with byte enables.
- Presents each assembled register to the register-file write port through a single-entry valid/ready output buffer.
- Tracks the destination register across multi-register (LMUL>1) groups and reports busy status for hazard logic.

Parameters:
- DIV_OP_W, 64, width of one result chunk in bits; power of 2, >= 32.
- VREG_W, 128, vector register width in bits; power of 2, multiple of DIV_OP_W.
- DONT_CARE_ZERO, 1'b0, drive don't-care data bytes to 0 instead of 'x.

Ports:
- clk_i  in  1  clock, rising edge.
- sync_rst_i  in  1  reset, synchronous, active-high.
- pipe_in_valid_i  in  1  result chunk valid.
- pipe_in_ready_o  out  1  chunk accepted when valid & ready.
- pipe_in_res_i  in  DIV_OP_W  result chunk data.
- pipe_in_mask_i  in  DIV_OP_W/8  byte write mask of chunk.
- pipe_in_first_i  in  1  first chunk of an instruction.
- pipe_in_last_i  in  1  last chunk of an instruction.
- pipe_in_vd_i  in  5  destination base register; sampled only with first_i.
- vreg_wr_valid_o  out  1  register write request.
- vreg_wr_ready_i  in  1  register file accepts the write.
- vreg_wr_addr_o  out  5  destination register index.
- vreg_wr_data_o  out  VREG_W  write data.
- vreg_wr_be_o  out  VREG_W/8  byte enables.
- busy_o  out  1  partial accumulation or pending write present.
- err_o  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset is synchronous, active-high, and has priority over all other updates.
- Reset values: vreg_wr_valid_o=0, err_o=0, busy_o=0. Slot counter, byte-enable accumulator and vd counter are cleared. Data registers are not reset.
- Reset mid-operation discards partial data and any pending write; no write is emitted afterwards.
- Constants: CHUNKS = VREG_W/DIV_OP_W; slot counter width = max(1, log2(CHUNKS)).
- Chunk acceptance:
  - The accepted chunk goes to slot s (0 if first_i, else current counter).
  - Data is written to acc_data[s*DIV_OP_W +: DIV_OP_W]; acc_be for the slot is set to mask_i.
  - Bytes with mask 0 hold 0 if DONT_CARE_ZERO, else don't care.
- Completion:
  - A chunk completes a register if s==CHUNKS-1 or last_i=1.
  - On completion, the merged accumulation (including the current chunk, combinational merge) loads the output buffer in the same cycle.
  - Output address = vd counter.
  - Slot counter and acc_be clear.
  - vd counter increments mod 32 unless last_i.
  - Otherwise the slot counter increments.
- Ready: pipe_in_ready_o = ~completes | ~vreg_wr_valid_o | vreg_wr_ready_i.
  - Non-completing chunks are never stalled.
  - Ready may depend combinationally on vreg_wr_ready_i.
- Output buffer:
  - vreg_wr_valid_o rises the cycle after a completing acceptance.
  - It holds address, data and be stable until vreg_wr_ready_i.
  - Simultaneous accept-out and new completion: the buffer reloads and valid stays 1 (back-to-back, one write per cycle).
- Latency: the last chunk of a register is visible at vreg_wr_* one cycle after acceptance.
- first_i handling:
  - Latches pipe_in_vd_i into the vd counter.
  - first_i & last_i emits a single write at vd_i with only slot 0 enabled.
  - first_i while the slot counter != 0 or acc_be != 0: the partial data is dropped and err_o pulses the next cycle.
- A write is emitted even if all its byte enables are 0, so the register file sees consistent sequencing.
- busy_o = (slot counter != 0) | vreg_wr_valid_o.
- vd counter wraps 31 -> 0 without error.

Decomposition:
- vproc_pkg gets:
  - VREG_IDX_W=5.
  - A vreg_wr_t struct {addr, data, be} parameterised via localparams inside the module, since package types cannot take parameters.
- No sub-module. The output buffer is a single register stage within this module; total expected size is ~200 lines of RTL.

Test Plan:
All scenarios use VREG_W=128, DIV_OP_W=64.
- Reset then idle -> vreg_wr_valid_o=0, busy_o=0, pipe_in_ready_o=1.
- Two chunks: first(vd=3, res=0x1111..., mask=0xFF), then last(res=0x2222..., mask=0x0F) -> one write: addr=3, data[63:0]=0x1111..., data[95:64]=0x22222222, be=0x0FFF, one cycle after the second accept.
- Four chunks with only first on chunk 0 (vd=31) and last on chunk 3 -> writes to addr 31 then addr 0 (wrap), be=0xFFFF each.
- vreg_wr_ready_i=0 for 5 cycles while a register is pending and a completing chunk arrives -> pipe_in_ready_o=0 for those cycles, output stable. On ready=1: back-to-back writes, no loss.
- first_i arriving after one non-last chunk -> err_o pulses exactly once; the new instruction's write carries only new data and the new vd.
- sync_rst_i asserted with one slot filled and a write pending -> next cycle valid=0, busy_o=0; subsequent instruction writes correctly from slot 0.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared vector-processor definitions.
// Holds the register-index width used by the DIV result packer; the packer's
// write payload struct depends on its own width parameters and so is declared
// inside that module.
package vproc_pkg;

  localparam int unsigned VREG_IDX_W = 5;

endpackage

// File: rtl/vproc_div_res_pack.sv
// DIV result packer: gathers DIV_OP_W-wide result chunks from the DIV result
// buffer into full VREG_W-wide register writes with byte enables, and offers
// each finished register through a one-entry valid/ready write buffer.
//
// Ports:
//   clk_i, sync_rst_i          clock, synchronous active-high reset
//   pipe_in_valid_i/ready_o    chunk handshake
//   pipe_in_res_i/mask_i       chunk data and byte mask
//   pipe_in_first_i/last_i     instruction framing
//   pipe_in_vd_i               base destination register (taken with first_i)
//   vreg_wr_valid_o/ready_i    register-file write handshake
//   vreg_wr_addr_o/data_o/be_o register-file write payload
//   busy_o                     partial register or pending write present
//   err_o                      one-cycle pulse when first_i drops a partial register
module vproc_div_res_pack
  import vproc_pkg::*;
#(
  parameter int unsigned DIV_OP_W       = 64,
  parameter int unsigned VREG_W         = 128,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    sync_rst_i,
  input  logic                    pipe_in_valid_i,
  output logic                    pipe_in_ready_o,
  input  logic [DIV_OP_W-1:0]     pipe_in_res_i,
  input  logic [DIV_OP_W/8-1:0]   pipe_in_mask_i,
  input  logic                    pipe_in_first_i,
  input  logic                    pipe_in_last_i,
  input  logic [VREG_IDX_W-1:0]   pipe_in_vd_i,
  output logic                    vreg_wr_valid_o,
  input  logic                    vreg_wr_ready_i,
  output logic [VREG_IDX_W-1:0]   vreg_wr_addr_o,
  output logic [VREG_W-1:0]       vreg_wr_data_o,
  output logic [VREG_W/8-1:0]     vreg_wr_be_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned CHUNKS     = VREG_W / DIV_OP_W;
  localparam int unsigned SLOT_W     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned OP_BYTES   = DIV_OP_W / 8;
  localparam int unsigned VREG_BYTES = VREG_W / 8;

  typedef struct packed {
    logic [VREG_IDX_W-1:0] addr;
    logic [VREG_W-1:0]     data;
    logic [VREG_BYTES-1:0] be;
  } vreg_wr_t;

  logic [SLOT_W-1:0]     slot_q;
  logic [VREG_W-1:0]     acc_data_q;
  logic [VREG_BYTES-1:0] acc_be_q;
  logic [VREG_IDX_W-1:0] vd_q;
  vreg_wr_t              out_q;
  logic                  out_valid_q;
  logic                  err_q;

  logic [SLOT_W-1:0]     slot_c;
  logic                  completes_c;
  logic                  accept_c;
  logic                  ready_c;
  logic                  err_d_c;
  logic [VREG_IDX_W-1:0] vd_cur_c;
  logic [VREG_W-1:0]     merged_data_c;
  logic [VREG_BYTES-1:0] merged_be_c;
  logic [VREG_W-1:0]     out_data_c;

  // Slot selection, completion and merge of the incoming chunk into the accumulator
  always_comb begin
    slot_c        = pipe_in_first_i ? '0 : slot_q;
    completes_c   = (slot_c == SLOT_W'(CHUNKS - 1)) | pipe_in_last_i;
    ready_c       = ~completes_c | ~out_valid_q | vreg_wr_ready_i;
    accept_c      = pipe_in_valid_i & ready_c;
    vd_cur_c      = pipe_in_first_i ? pipe_in_vd_i : vd_q;
    // first_i abandons whatever partial register was being gathered
    err_d_c       = accept_c & pipe_in_first_i & ((slot_q != '0) | (|acc_be_q));
    merged_data_c = acc_data_q;
    merged_be_c   = pipe_in_first_i ? '0 : acc_be_q;
    for (int i = 0; i < int'(CHUNKS); i++) begin
      if (slot_c == SLOT_W'(i)) begin
        merged_data_c[i*DIV_OP_W +: DIV_OP_W] = pipe_in_res_i;
        merged_be_c[i*OP_BYTES +: OP_BYTES]   = pipe_in_mask_i;
      end
    end
    // Zeroing at the output also hides stale bytes from dropped or older registers
    out_data_c = merged_data_c;
    if (DONT_CARE_ZERO) begin
      for (int b = 0; b < int'(VREG_BYTES); b++) begin
        if (!merged_be_c[b]) out_data_c[b*8 +: 8] = 8'h00;
      end
    end
  end

  // Control state: slot counter, byte enables, vd counter, output valid, error pulse
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      slot_q      <= '0;
      acc_be_q    <= '0;
      vd_q        <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d_c;
      if (accept_c) begin
        if (completes_c) begin
          slot_q   <= '0;
          acc_be_q <= '0;
          vd_q     <= pipe_in_last_i ? vd_cur_c : vd_cur_c + VREG_IDX_W'(1);
        end else begin
          slot_q   <= slot_c + SLOT_W'(1);
          acc_be_q <= merged_be_c;
          vd_q     <= vd_cur_c;
        end
      end
      if (accept_c && completes_c) begin
        out_valid_q <= 1'b1;
      end else if (vreg_wr_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Data storage; byte enables and valid decide what is meaningful, so no reset
  always_ff @(posedge clk_i) begin
    if (accept_c && !completes_c) begin
      acc_data_q <= merged_data_c;
    end
    if (accept_c && completes_c) begin
      out_q.addr <= vd_cur_c;
      out_q.data <= out_data_c;
      out_q.be   <= merged_be_c;
    end
  end

  assign pipe_in_ready_o = ready_c;
  assign vreg_wr_valid_o = out_valid_q;
  assign vreg_wr_addr_o  = out_q.addr;
  assign vreg_wr_data_o  = out_q.data;
  assign vreg_wr_be_o    = out_q.be;
  assign busy_o          = (slot_q != '0) | out_valid_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_vproc_div_res_pack.sv
// Randomized bench for vproc_div_res_pack (DIV_OP_W=64, VREG_W=128, zeroed
// don't-care bytes) against a byte-array reference model of register assembly.
module tb_vproc_div_res_pack;

  localparam int CH = 2;
  localparam int VB = 16;
  localparam int OB = 8;

  logic         clk_i = 1'b0;
  logic         sync_rst_i;
  logic         pipe_in_valid_i;
  logic         pipe_in_ready_o;
  logic [63:0]  pipe_in_res_i;
  logic [7:0]   pipe_in_mask_i;
  logic         pipe_in_first_i;
  logic         pipe_in_last_i;
  logic [4:0]   pipe_in_vd_i;
  logic         vreg_wr_valid_o;
  logic         vreg_wr_ready_i;
  logic [4:0]   vreg_wr_addr_o;
  logic [127:0] vreg_wr_data_o;
  logic [15:0]  vreg_wr_be_o;
  logic         busy_o;
  logic         err_o;

  vproc_div_res_pack #(
    .DIV_OP_W      (64),
    .VREG_W        (128),
    .DONT_CARE_ZERO(1'b1)
  ) dut (
    .clk_i          (clk_i),
    .sync_rst_i     (sync_rst_i),
    .pipe_in_valid_i(pipe_in_valid_i),
    .pipe_in_ready_o(pipe_in_ready_o),
    .pipe_in_res_i  (pipe_in_res_i),
    .pipe_in_mask_i (pipe_in_mask_i),
    .pipe_in_first_i(pipe_in_first_i),
    .pipe_in_last_i (pipe_in_last_i),
    .pipe_in_vd_i   (pipe_in_vd_i),
    .vreg_wr_valid_o(vreg_wr_valid_o),
    .vreg_wr_ready_i(vreg_wr_ready_i),
    .vreg_wr_addr_o (vreg_wr_addr_o),
    .vreg_wr_data_o (vreg_wr_data_o),
    .vreg_wr_be_o   (vreg_wr_be_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  vd;
    logic [63:0] res;
    logic [7:0]  mask;
    bit          first;
    bit          last;
  } chunk_t;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  // Reference model state: bytes gathered so far for the current register
  int          m_slot;
  bit          m_be [VB];
  logic [7:0]  m_dat[VB];
  int          m_vd;
  chunk_t      cq[$];
  wr_t         wq[$];
  bit          exp_err;

  int          ready_mode;  // 0 random, 1 held low, 2 held high
  bit          dense;
  int          n_checks;
  int          n_fail;
  int          err_seen;
  int          writes_seen;
  logic [4:0]   last_addr;
  logic [127:0] last_data;
  logic [15:0]  last_be;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_slot = 0;
    m_vd   = 0;
    for (int b = 0; b < VB; b++) m_be[b] = 1'b0;
    wq.delete();
    cq.delete();
    exp_err = 1'b0;
  endtask

  task automatic model_accept(input chunk_t c);
    int  s;
    bit  any;
    wr_t w;
    s = c.first ? 0 : m_slot;
    if (c.first) begin
      any = 1'b0;
      for (int b = 0; b < VB; b++) any |= m_be[b];
      if (m_slot != 0 || any) exp_err = 1'b1;
      for (int b = 0; b < VB; b++) m_be[b] = 1'b0;
      m_vd = int'(c.vd);
    end
    for (int b = 0; b < OB; b++) begin
      m_be[s*OB + b]  = c.mask[b];
      m_dat[s*OB + b] = c.res[b*8 +: 8];
    end
    if (s == CH - 1 || c.last) begin
      w.addr = 5'(m_vd);
      for (int b = 0; b < VB; b++) begin
        w.be[b]         = m_be[b];
        w.data[b*8 +: 8] = m_be[b] ? m_dat[b] : 8'h00;
        m_be[b]         = 1'b0;
      end
      wq.push_back(w);
      m_slot = 0;
      if (!c.last) m_vd = (m_vd + 1) % 32;
    end else begin
      m_slot = s + 1;
    end
  endtask

  // One clock cycle: drive at negedge, check shortly after, advance model
  task automatic step();
    chunk_t c;
    bit     v;
    bit     wrr;
    bit     comp;
    bit     rdy_exp;
    int     s;
    @(negedge clk_i);
    v = (cq.size() != 0) && (dense || $urandom_range(0, 3) != 0);
    if (v) begin
      c = cq[0];
    end else begin
      c.vd    = 5'($urandom);
      c.res   = {$urandom, $urandom};
      c.mask  = 8'($urandom);
      c.first = 1'($urandom);
      c.last  = 1'($urandom);
    end
    case (ready_mode)
      0:       wrr = ($urandom_range(0, 2) != 0);
      1:       wrr = 1'b0;
      default: wrr = 1'b1;
    endcase
    pipe_in_valid_i = v;
    pipe_in_res_i   = c.res;
    pipe_in_mask_i  = c.mask;
    pipe_in_first_i = c.first;
    pipe_in_last_i  = c.last;
    pipe_in_vd_i    = c.vd;
    vreg_wr_ready_i = wrr;
    #1;
    s       = c.first ? 0 : m_slot;
    comp    = (s == CH - 1) || c.last;
    rdy_exp = !comp || wq.size() == 0 || wrr;
    check_eq("wr_valid", 128'(vreg_wr_valid_o), 128'(wq.size() != 0));
    check_eq("in_ready", 128'(pipe_in_ready_o), 128'(rdy_exp));
    check_eq("busy", 128'(busy_o), 128'(m_slot != 0 || wq.size() != 0));
    check_eq("err", 128'(err_o), 128'(exp_err));
    if (err_o) err_seen++;
    if (wq.size() != 0) begin
      check_eq("wr_addr", 128'(vreg_wr_addr_o), 128'(wq[0].addr));
      check_eq("wr_data", vreg_wr_data_o, wq[0].data);
      check_eq("wr_be", 128'(vreg_wr_be_o), 128'(wq[0].be));
      if (wrr) begin
        void'(wq.pop_front());
        writes_seen++;
        last_addr = vreg_wr_addr_o;
        last_data = vreg_wr_data_o;
        last_be   = vreg_wr_be_o;
      end
    end
    exp_err = 1'b0;
    if (v && rdy_exp) begin
      void'(cq.pop_front());
      model_accept(c);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((cq.size() != 0 || wq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    check_eq("drain_done", 128'(cq.size() + wq.size()), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    sync_rst_i      = 1'b1;
    pipe_in_valid_i = 1'b0;
    vreg_wr_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    sync_rst_i = 1'b0;
    model_clear();
  endtask

  task automatic push(input logic [4:0] vd, input logic [63:0] res, input logic [7:0] mask,
                      input bit first, input bit last);
    chunk_t c;
    c.vd = vd; c.res = res; c.mask = mask; c.first = first; c.last = last;
    cq.push_back(c);
  endtask

  initial begin
    int w0;
    int e0;
    int n;
    n_checks = 0; n_fail = 0; err_seen = 0; writes_seen = 0;
    sync_rst_i = 1'b1; pipe_in_valid_i = 1'b0; pipe_in_res_i = '0; pipe_in_mask_i = '0;
    pipe_in_first_i = 1'b0; pipe_in_last_i = 1'b0; pipe_in_vd_i = '0; vreg_wr_ready_i = 1'b0;
    dense = 1'b1;
    ready_mode = 2;
    do_reset();

    // Idle after reset
    step();
    step();

    // Two chunks with a partial mask on the last one
    push(5'd3, 64'h1111_1111_1111_1111, 8'hFF, 1'b1, 1'b0);
    push(5'd0, 64'h2222_2222_2222_2222, 8'h0F, 1'b0, 1'b1);
    drain(20);
    check_eq("two_chunk_addr", 128'(last_addr), 128'(3));
    check_eq("two_chunk_be", 128'(last_be), 128'h0FFF);
    check_eq("two_chunk_data", last_data, {32'h0, 32'h2222_2222, 64'h1111_1111_1111_1111});

    // LMUL=2 group starting at v31 wraps to v0
    w0 = writes_seen;
    push(5'd31, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 1'b1, 1'b0);
    push(5'd0,  64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1'b0, 1'b0);
    push(5'd0,  64'hA2A2_A2A2_A2A2_A2A2, 8'hFF, 1'b0, 1'b0);
    push(5'd0,  64'hA3A3_A3A3_A3A3_A3A3, 8'hFF, 1'b0, 1'b1);
    drain(20);
    check_eq("wrap_writes", 128'(writes_seen - w0), 128'(2));
    check_eq("wrap_addr", 128'(last_addr), 128'(0));
    check_eq("wrap_be", 128'(last_be), 128'hFFFF);

    // Register file stalls while a second completing chunk waits
    w0 = writes_seen;
    ready_mode = 1;
    push(5'd7, 64'h7777_0000_7777_0000, 8'hFF, 1'b1, 1'b1);
    push(5'd8, 64'h8888_0000_8888_0000, 8'hF0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check_eq("stall_held", 128'(cq.size()), 128'(1));
    ready_mode = 2;
    drain(20);
    check_eq("stall_writes", 128'(writes_seen - w0), 128'(2));
    check_eq("stall_last_addr", 128'(last_addr), 128'(8));

    // first_i interrupting a partial register
    e0 = err_seen;
    push(5'd5, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b0);
    push(5'd9, 64'h9999_9999_9999_9999, 8'hFF, 1'b1, 1'b0);
    push(5'd0, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 1'b1);
    drain(20);
    step();
    check_eq("abort_err_once", 128'(err_seen - e0), 128'(1));
    check_eq("abort_addr", 128'(last_addr), 128'(9));
    check_eq("abort_data", last_data, {64'hBBBB_BBBB_BBBB_BBBB, 64'h9999_9999_9999_9999});

    // Reset with a write pending and a slot filled
    ready_mode = 1;
    push(5'd2, 64'h2020_2020_2020_2020, 8'hFF, 1'b1, 1'b1);
    push(5'd4, 64'h4040_4040_4040_4040, 8'hFF, 1'b1, 1'b0);
    n = 0;
    while (cq.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check_eq("pre_reset_busy", 128'(busy_o), 128'(1));
    w0 = writes_seen;
    do_reset();
    ready_mode = 2;
    step();
    check_eq("post_reset_valid", 128'(vreg_wr_valid_o), 128'(0));
    check_eq("post_reset_busy", 128'(busy_o), 128'(0));
    push(5'd6, 64'h6060_6060_6060_6060, 8'hFF, 1'b1, 1'b0);
    push(5'd0, 64'h6161_6161_6161_6161, 8'h3C, 1'b0, 1'b1);
    drain(20);
    check_eq("post_reset_writes", 128'(writes_seen - w0), 128'(1));
    check_eq("post_reset_addr", 128'(last_addr), 128'(6));
    check_eq("post_reset_be", 128'(last_be), 128'h3CFF);

    // Random instruction stream with valid gaps and write-port back-pressure
    dense = 1'b0;
    ready_mode = 0;
    for (int k = 0; k < 80; k++) begin
      int     nch;
      bit     abort;
      logic [4:0] vd;
      logic [7:0] mk;
      nch   = $urandom_range(1, 8);
      abort = ($urandom_range(0, 7) == 0);
      vd    = 5'($urandom);
      for (int j = 0; j < nch; j++) begin
        case ($urandom_range(0, 3))
          0:       mk = 8'hFF;
          1:       mk = 8'h00;
          default: mk = 8'($urandom);
        endcase
        push(vd, {$urandom, $urandom}, mk, j == 0, (j == nch - 1) && !abort);
      end
      drain(200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
